// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs2;
  logic              id_is_mul;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;

  logic              stall;
  logic              id_stall;
  logic              bubble_ex;
  logic              ex_hold;
  logic              flush_id;
  logic              pc_redirect;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mul_busy;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs2, id_is_mul,
           ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write,
    input  stall, id_stall, bubble_ex, ex_hold, flush_id, pc_redirect,
           fwd_a, fwd_b, mul_busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs2, id_is_mul,
           ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write,
    output stall, id_stall, bubble_ex, ex_hold, flush_id, pc_redirect,
           fwd_a, fwd_b, mul_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: branch squash, load-use stall, multi-cycle
// multiply sequencing, operand forwarding selects and a saturating stall counter.
module hazard_fwd_sel #(
  parameter int REG_AW = 3
) (
  input  logic              use_rs,
  input  logic [REG_AW-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel
);
  logic ex_hit, mem_hit;

  // Loads in EX have no result yet; those are covered by the load-use stall.
  assign ex_hit  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd != '0) & (ex_rd == rs);
  assign mem_hit = mem_reg_write & (mem_rd != '0) & (mem_rd == rs);

  always_comb begin
    sel = 2'b00;
    if (use_rs) begin
      if (ex_hit)       sel = 2'b01;
      else if (mem_hit) sel = 2'b10;
    end
  end
endmodule

module hazard_ctrl #(
  parameter int REG_AW     = 3,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rstn,
  hazard_ctrl_if.slave  hz
);
  localparam int              MCW      = $clog2(MUL_CYCLES);
  localparam logic [MCW-1:0]  MUL_LOAD = MCW'(MUL_CYCLES - 1);

  typedef enum logic {RUN, MUL} state_t;

  state_t           state;
  logic [MCW-1:0]   mul_cnt;
  logic [CNT_W-1:0] cnt_q;

  logic load_use, branch, mul_start;
  logic stall, id_stall, bubble_ex, ex_hold, flush_id, pc_redirect, mul_busy;

  assign load_use = hz.id_valid & hz.ex_valid & hz.ex_mem_read & hz.ex_reg_write &
                    (hz.ex_rd != '0) &
                    ((hz.ex_rd == hz.id_rs1) | (hz.id_use_rs2 & (hz.ex_rd == hz.id_rs2)));
  assign branch    = hz.ex_valid & hz.ex_branch_taken;
  // A squashed or stalled ID multiply must not enter EX.
  assign mul_start = ~branch & ~load_use & hz.id_valid & hz.id_is_mul;

  always_comb begin
    stall       = 1'b0;
    id_stall    = 1'b0;
    bubble_ex   = 1'b0;
    ex_hold     = 1'b0;
    flush_id    = 1'b0;
    pc_redirect = 1'b0;
    mul_busy    = 1'b0;
    if (state == MUL) begin
      stall    = 1'b1;
      id_stall = 1'b1;
      ex_hold  = 1'b1;
      mul_busy = 1'b1;
    end else if (branch) begin
      pc_redirect = 1'b1;
      flush_id    = 1'b1;
      bubble_ex   = 1'b1;
    end else if (load_use) begin
      stall     = 1'b1;
      id_stall  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // MUL covers the MUL_CYCLES-1 cycles after the multiply's first EX cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      case (state)
        RUN: if (mul_start) begin
          state   <= MUL;
          mul_cnt <= MUL_LOAD;
        end
        MUL: begin
          mul_cnt <= mul_cnt - 1'b1;
          if (mul_cnt == MCW'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      cnt_q <= '0;
    else if (stall && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             use_rs;
  logic [1:0][1:0]        sel;

  assign rs     = {hz.id_rs2, hz.id_rs1};
  assign use_rs = {hz.id_use_rs2, 1'b1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .use_rs        (use_rs[i]),
      .rs            (rs[i]),
      .ex_valid      (hz.ex_valid),
      .ex_reg_write  (hz.ex_reg_write),
      .ex_mem_read   (hz.ex_mem_read),
      .ex_rd         (hz.ex_rd),
      .mem_reg_write (hz.mem_reg_write),
      .mem_rd        (hz.mem_rd),
      .sel           (sel[i])
    );
  end

  assign hz.stall       = stall;
  assign hz.id_stall    = id_stall;
  assign hz.bubble_ex   = bubble_ex;
  assign hz.ex_hold     = ex_hold;
  assign hz.flush_id    = flush_id;
  assign hz.pc_redirect = pc_redirect;
  assign hz.mul_busy    = mul_busy;
  assign hz.fwd_a       = sel[0];
  assign hz.fwd_b       = sel[1];
  assign hz.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default instance plus a CNT_W=4 instance for saturation.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) ifa ();
  hazard_ctrl_if #(.REG_AW(3), .CNT_W(4))  ifb ();

  hazard_ctrl #(.REG_AW(3), .MUL_CYCLES(4), .CNT_W(16)) u_dut_a (.clk(clk), .rstn(rstn), .hz(ifa));
  hazard_ctrl #(.REG_AW(3), .MUL_CYCLES(4), .CNT_W(4))  u_dut_b (.clk(clk), .rstn(rstn), .hz(ifb));

  // {stall, id_stall, bubble_ex, ex_hold, flush_id, pc_redirect, mul_busy}
  localparam logic [6:0] C_IDLE = 7'b000_0000;
  localparam logic [6:0] C_LU   = 7'b111_0000;
  localparam logic [6:0] C_BR   = 7'b001_0110;
  localparam logic [6:0] C_MUL  = 7'b110_1001;

  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.stall, ifa.id_stall, ifa.bubble_ex, ifa.ex_hold,
                  ifa.flush_id, ifa.pc_redirect, ifa.mul_busy};
  assign ctl_b = {ifb.stall, ifb.id_stall, ifb.bubble_ex, ifb.ex_hold,
                  ifb.flush_id, ifb.pc_redirect, ifb.mul_busy};

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_a();
    ifa.id_valid = 0; ifa.id_rs1 = 0; ifa.id_rs2 = 0; ifa.id_use_rs2 = 0; ifa.id_is_mul = 0;
    ifa.ex_valid = 0; ifa.ex_rd = 0; ifa.ex_reg_write = 0; ifa.ex_mem_read = 0;
    ifa.ex_branch_taken = 0; ifa.mem_rd = 0; ifa.mem_reg_write = 0;
  endtask

  task automatic zero_b();
    ifb.id_valid = 0; ifb.id_rs1 = 0; ifb.id_rs2 = 0; ifb.id_use_rs2 = 0; ifb.id_is_mul = 0;
    ifb.ex_valid = 0; ifb.ex_rd = 0; ifb.ex_reg_write = 0; ifb.ex_mem_read = 0;
    ifb.ex_branch_taken = 0; ifb.mem_rd = 0; ifb.mem_reg_write = 0;
  endtask

  // Load in EX writing r3, ID reads r3.
  task automatic load_use_a();
    ifa.id_valid = 1; ifa.id_rs1 = 3; ifa.ex_valid = 1;
    ifa.ex_mem_read = 1; ifa.ex_reg_write = 1; ifa.ex_rd = 3;
  endtask

  task automatic mul_start_a();
    zero_a(); ifa.id_valid = 1; ifa.id_is_mul = 1;
  endtask

  initial begin
    rstn = 0;
    zero_a(); zero_b();
    #3;
    chk("rst_ctl", ctl_a, C_IDLE);
    chk("rst_cnt", ifa.stall_count, 0);
    chk("rst_fwd", {ifa.fwd_a, ifa.fwd_b}, 0);
    @(negedge clk); rstn = 1;
    #1 chk("idle_ctl", ctl_a, C_IDLE);

    // Load-use: one-cycle stall, then clears once EX holds the bubble.
    @(negedge clk); load_use_a();
    #1 chk("lu_ctl", ctl_a, C_LU);
    chk("lu_fwd_a", ifa.fwd_a, 0);
    @(negedge clk);
    chk("lu_cnt", ifa.stall_count, 1);
    ifa.ex_valid = 0;
    #1 chk("lu_clear", ctl_a, C_IDLE);

    // Load-use through rs2.
    @(negedge clk); zero_a();
    ifa.id_valid = 1; ifa.id_rs1 = 1; ifa.id_use_rs2 = 1; ifa.id_rs2 = 4;
    ifa.ex_valid = 1; ifa.ex_mem_read = 1; ifa.ex_reg_write = 1; ifa.ex_rd = 4;
    #1 chk("lu_rs2", ctl_a, C_LU);
    // Load into r0 never stalls.
    @(negedge clk);
    chk("lu_rs2_cnt", ifa.stall_count, 2);
    ifa.ex_rd = 0; ifa.id_rs1 = 0; ifa.id_rs2 = 0;
    #1 chk("lu_r0", ctl_a, C_IDLE);

    // Forwarding.
    @(negedge clk); zero_a();
    ifa.id_valid = 1; ifa.id_rs1 = 2; ifa.ex_valid = 1; ifa.ex_reg_write = 1; ifa.ex_rd = 2;
    ifa.mem_reg_write = 1; ifa.mem_rd = 2;
    #1 chk("fwd_ex_pri", ifa.fwd_a, 2'b01);
    chk("fwd_ctl", ctl_a, C_IDLE);
    @(negedge clk); ifa.ex_rd = 5;
    #1 chk("fwd_mem", ifa.fwd_a, 2'b10);
    @(negedge clk); ifa.id_use_rs2 = 1; ifa.id_rs2 = 5;
    #1 chk("fwd_b_ex", ifa.fwd_b, 2'b01);
    @(negedge clk); ifa.id_use_rs2 = 0;
    #1 chk("fwd_b_gated", ifa.fwd_b, 2'b00);
    @(negedge clk); ifa.id_rs1 = 0; ifa.mem_rd = 0;
    #1 chk("fwd_r0", ifa.fwd_a, 2'b00);
    @(negedge clk); ifa.id_rs1 = 2; ifa.ex_rd = 2; ifa.mem_rd = 2; ifa.ex_valid = 0;
    #1 chk("fwd_ex_invalid", ifa.fwd_a, 2'b10);

    // Branch beats load-use; no stall counted.
    @(negedge clk); zero_a(); load_use_a(); ifa.ex_branch_taken = 1;
    #1 chk("br_lu_ctl", ctl_a, C_BR);
    @(negedge clk);
    chk("br_cnt", ifa.stall_count, 2);

    // Multiply: 3 MUL cycles, branch and load-use ignored inside.
    mul_start_a();
    #1 chk("mul_start", ctl_a, C_IDLE);
    @(negedge clk); zero_a();
    #1 chk("mul_c1", ctl_a, C_MUL);
    @(negedge clk); ifa.ex_valid = 1; ifa.ex_branch_taken = 1;
    #1 chk("mul_c2_br", ctl_a, C_MUL);
    @(negedge clk); zero_a(); load_use_a();
    #1 chk("mul_c3_lu", ctl_a, C_MUL);
    @(negedge clk); zero_a();
    #1 chk("mul_done", ctl_a, C_IDLE);
    chk("mul_cnt", ifa.stall_count, 5);

    // Reset during the 2nd MUL cycle.
    @(negedge clk); mul_start_a();
    @(negedge clk); zero_a();
    @(negedge clk);
    #1 chk("rmul_c2", ctl_a, C_MUL);
    #1 rstn = 0;
    #1 chk("rmul_ctl", ctl_a, C_IDLE);
    chk("rmul_cnt", ifa.stall_count, 0);
    @(negedge clk); rstn = 1; mul_start_a();
    #1 chk("rmul_start", ctl_a, C_IDLE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); zero_a();
      #1 chk($sformatf("rmul_c%0d", i + 1), ctl_a, C_MUL);
    end
    @(negedge clk);
    #1 chk("rmul_done", ctl_a, C_IDLE);
    chk("rmul_cnt3", ifa.stall_count, 3);

    // Saturation on the 4-bit counter.
    chk("sat_start", ifb.stall_count, 0);
    ifb.id_valid = 1; ifb.id_rs1 = 6; ifb.ex_valid = 1;
    ifb.ex_mem_read = 1; ifb.ex_reg_write = 1; ifb.ex_rd = 6;
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk("sat_14", ifb.stall_count, 14);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("sat_20", ifb.stall_count, 15);
    chk("sat_stall", ctl_b, C_LU);
    zero_b();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
